alu_share_arbiter: RTL and testbench

//  Shares one combinational 32-bit ALU (ALUControl 00=ADD, 01=SUB, 10=AND, 11=OR;

---
 rtl/alu_share_arbiter.sv | 118 +++++++++++
 tb/tb_alu_share_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one external combinational ALU between
// N_REQ requesters. At most one operation is issued per cycle. The ALU result
// and flags are captured into a single-entry response slot tagged with the
// id of the requester that issued the operation.
module alu_share_arbiter #(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 32,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_a,
  input  logic [WIDTH*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [1:0]             alu_control,
  input  logic [WIDTH-1:0]       alu_result,
  input  logic [3:0]             alu_flags,
  output logic                   rsp_valid,
  output logic [IDW-1:0]         rsp_id,
  output logic [WIDTH-1:0]       rsp_result,
  output logic [3:0]             rsp_flags,
  input  logic                   rsp_ready
);

  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q,    rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]       rsp_flags_q, rsp_flags_d;
  logic [IDW-1:0]   rr_ptr_q,    rr_ptr_d;

  logic             slot_free;
  logic             gnt_found;
  logic [IDW-1:0]   gnt_id;
  logic [IDW-1:0]   cand;
  logic             grant;

  // The slot may be drained and refilled in the same cycle.
  assign slot_free = ~rsp_valid_q | rsp_ready;
  // No grants are issued while reset is held.
  assign grant     = reset & slot_free & gnt_found;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    cand      = rr_ptr_q;
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (cand == IDW'(N_REQ-1)) ? '0 : cand + IDW'(1);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  // One-hot ready towards the winner; depends only on valids and slot state.
  always_comb begin
    req_ready = '0;
    if (grant) req_ready[gnt_id] = 1'b1;
  end

  // Steer the winner's operands to the ALU; idle inputs are zero.
  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_control = '0;
    if (grant) begin
      alu_a       = req_a[WIDTH*gnt_id +: WIDTH];
      alu_b       = req_b[WIDTH*gnt_id +: WIDTH];
      alu_control = req_op[2*gnt_id +: 2];
    end
  end

  // Response slot next state: capture on grant, empty on drain, else hold.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rr_ptr_d     = rr_ptr_q;
    if (grant) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = gnt_id;
      rsp_result_d = alu_result;
      rsp_flags_d  = alu_flags;
      rr_ptr_d     = gnt_id;
    end else if (rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  // State registers; reset discards any pending response and restarts at requester 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rr_ptr_q     <= IDW'(N_REQ-1);
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a behavioural ALU sits on the ALU port,
// expected responses are queued when a grant is expected and compared when
// the response slot fills.
module tb_alu_share_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [2*N-1:0] req_op;
  logic [W*N-1:0] req_a, req_b;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   alu_a, alu_b, alu_result;
  logic [1:0]     alu_control;
  logic [3:0]     alu_flags;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_result;
  logic [3:0]     rsp_flags;
  logic           rsp_ready;

  alu_share_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: 00 ADD, 01 SUB, 10 AND, 11 OR; flags {N,Z,C,V}.
  logic [32:0] s;
  logic        v;
  always_comb begin
    s = '0;
    v = 1'b0;
    case (alu_control)
      2'b00: begin
        s = {1'b0, alu_a} + {1'b0, alu_b};
        v = (alu_a[31] == alu_b[31]) && (s[31] != alu_a[31]);
      end
      2'b01: begin
        s = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        v = (alu_a[31] != alu_b[31]) && (s[31] != alu_a[31]);
      end
      2'b10: s = {1'b0, alu_a & alu_b};
      default: s = {1'b0, alu_a | alu_b};
    endcase
    alu_result = s[31:0];
    alu_flags  = {s[31], (s[31:0] == 32'd0), (alu_control[1] ? 1'b0 : s[32]), v};
  end

  typedef struct {
    int          req;
    logic [1:0]  op;
    logic [31:0] a, b, res;
    logic [3:0]  fl;
  } vec_t;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] res;
    logic [3:0]  fl;
  } exp_t;

  vec_t vt[8];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input int id, input logic [31:0] res, input logic [3:0] fl);
    exp_t e;
    e.id = 2'(id); e.res = res; e.fl = fl;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: response with empty scoreboard", nm);
    end else begin
      e = sb.pop_front();
      chk({nm, ".valid"},  32'(rsp_valid),  32'd1);
      chk({nm, ".id"},     32'(rsp_id),     32'(e.id));
      chk({nm, ".result"}, rsp_result,      e.res);
      chk({nm, ".flags"},  32'(rsp_flags),  32'(e.fl));
    end
  endtask

  task automatic set_req(input int r, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[2*r +: 2] = op;
    req_a[W*r +: W]  = a;
    req_b[W*r +: W]  = b;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    vt[0] = '{0, 2'b00, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110};
    vt[1] = '{1, 2'b00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001};
    vt[2] = '{2, 2'b01, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b1000};
    vt[3] = '{3, 2'b01, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011};
    vt[4] = '{0, 2'b10, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 4'b0100};
    vt[5] = '{1, 2'b11, 32'h12340000, 32'h00005678, 32'h12345678, 4'b0000};
    vt[6] = '{2, 2'b00, 32'h80000000, 32'h80000000, 32'h00000000, 4'b0111};
    vt[7] = '{3, 2'b01, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110};

    // Reset with requests pending: nothing granted, slot cleared.
    reset = 1'b0; req_valid = '1; req_op = '0; req_a = '1; req_b = '1; rsp_ready = 1'b1;
    @(negedge clk);
    tick();
    chk("rst.ready",  32'(req_ready),  32'd0);
    chk("rst.valid",  32'(rsp_valid),  32'd0);
    chk("rst.id",     32'(rsp_id),     32'd0);
    chk("rst.result", rsp_result,      32'd0);
    chk("rst.flags",  32'(rsp_flags),  32'd0);
    req_valid = '0; reset = 1'b1;

    // Table: one requester at a time, ALU function and flag pass-through.
    for (int i = 0; i < 8; i++) begin
      req_valid = '0;
      req_valid[vt[i].req] = 1'b1;
      set_req(vt[i].req, vt[i].op, vt[i].a, vt[i].b);
      #1;
      chk($sformatf("vec%0d.ready", i), 32'(req_ready), 32'(4'b0001 << vt[i].req));
      chk($sformatf("vec%0d.alu_a", i), alu_a, vt[i].a);
      push(vt[i].req, vt[i].res, vt[i].fl);
      tick();
      req_valid = '0;
      pop_chk($sformatf("vec%0d", i));
    end

    // All four valid: round-robin 0,1,2,3,0 back to back.
    do_reset();
    req_valid = '1;
    for (int r = 0; r < N; r++) set_req(r, 2'b01, 32'd5, 32'd5);
    for (int n = 0; n < 5; n++) begin
      #1;
      chk($sformatf("rr%0d.ready", n), 32'(req_ready), 32'(4'b0001 << (n % 4)));
      push(n % 4, 32'd0, 4'b0110);
      tick();
      pop_chk($sformatf("rr%0d", n));
    end

    // Backpressure: held response blocks further grants, drain+grant same cycle.
    do_reset();
    req_valid = 4'b0010;
    set_req(1, 2'b10, 32'hF0F0F0F0, 32'hFF00FF00);
    #1;
    chk("bp.ready1", 32'(req_ready), 32'b0010);
    push(1, 32'hF000F000, 4'b1000);
    tick();
    req_valid = 4'b0100;
    set_req(2, 2'b00, 32'd1, 32'd2);
    rsp_ready = 1'b0;
    pop_chk("bp.cap");
    for (int n = 0; n < 3; n++) begin
      #1;
      chk($sformatf("bp%0d.ready", n), 32'(req_ready), 32'd0);
      tick();
      chk($sformatf("bp%0d.valid", n), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp%0d.id", n),    32'(rsp_id),    32'd1);
      chk($sformatf("bp%0d.res", n),   rsp_result,     32'hF000F000);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp.ready2", 32'(req_ready), 32'b0100);
    push(2, 32'd3, 4'b0000);
    tick();
    req_valid = '0;
    pop_chk("bp.refill");

    // Single requester 3: granted every cycle, pointer wraps onto itself.
    req_valid = 4'b1000;
    set_req(3, 2'b11, 32'h80000000, 32'h0);
    for (int n = 0; n < 4; n++) begin
      #1;
      chk($sformatf("r3_%0d.ready", n), 32'(req_ready), 32'b1000);
      push(3, 32'h80000000, 4'b1000);
      tick();
      pop_chk($sformatf("r3_%0d", n));
    end

    // Reset while a response is pending and requests are valid.
    req_valid = '1;
    for (int r = 0; r < N; r++) set_req(r, 2'b00, 32'd1, 32'd1);
    #1;
    chk("mr.ready0", 32'(req_ready), 32'b0001);
    push(0, 32'd2, 4'b0000);
    tick();
    pop_chk("mr.pre");
    rsp_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk("mr.ready_rst", 32'(req_ready), 32'd0);
    tick();
    chk("mr.valid",  32'(rsp_valid), 32'd0);
    chk("mr.result", rsp_result,     32'd0);
    chk("mr.ready",  32'(req_ready), 32'd0);
    reset = 1'b1;
    req_valid = 4'b1100;
    #1;
    chk("mr.first", 32'(req_ready), 32'b0100);
    push(2, 32'd2, 4'b0000);
    tick();
    pop_chk("mr.post");

    // Idle: ALU inputs zero, slot drains and stays empty.
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      #1;
      chk($sformatf("idle%0d.alu", n),
          {alu_a[15:0], alu_b[13:0], alu_control}, 32'd0);
      chk($sformatf("idle%0d.aluhi", n), {alu_a[31:16], alu_b[31:16]}, 32'd0);
      chk($sformatf("idle%0d.ready", n), 32'(req_ready), 32'd0);
      tick();
      chk($sformatf("idle%0d.valid", n), 32'(rsp_valid), 32'd0);
    end
    chk("idle.alu_b_lo", 32'(alu_b[15:14]), 32'd0);
    chk("sb.empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
